// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: geometry, column drive
// patterns, FSM state encoding and pattern helper functions.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W   = 4;
  localparam int SNAP_W   = NUM_COLS * NUM_ROWS;

  // One-cold, active-low column drive patterns
  localparam logic [NUM_COLS-1:0] COL_SEL_0 = 4'b1110;
  localparam logic [NUM_COLS-1:0] COL_SEL_1 = 4'b1101;
  localparam logic [NUM_COLS-1:0] COL_SEL_2 = 4'b1011;
  localparam logic [NUM_COLS-1:0] COL_SEL_3 = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_MULTI   = 2'd2
  } key_state_e;

  // Column drive pattern for a given column index
  function automatic logic [NUM_COLS-1:0] col_sel_pattern(input logic [1:0] idx);
    logic [NUM_COLS-1:0] pat;
    case (idx)
      2'd0:    pat = COL_SEL_0;
      2'd1:    pat = COL_SEL_1;
      2'd2:    pat = COL_SEL_2;
      2'd3:    pat = COL_SEL_3;
      default: pat = COL_SEL_0;
    endcase
    return pat;
  endfunction

  // True when exactly one bit of the snapshot is set
  function automatic logic popcount_is_one(input logic [SNAP_W-1:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < SNAP_W; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return (cnt == 5'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Snapshot debouncer: a full-matrix pattern is accepted once it has been
// seen unchanged on DEBOUNCE_SCANS consecutive completed scans, and is
// re-accepted on every further identical scan.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              scan_done,
  input  logic [SNAP_W-1:0] snapshot,
  output logic [SNAP_W-1:0] accepted,
  output logic              accept
);

  localparam int CNT_W = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [SNAP_W-1:0] prev_snap_r;
  logic [CNT_W-1:0]  match_cnt_r;
  logic              same_s;
  logic [CNT_W-1:0]  cnt_next_s;

  // Compare against the previous snapshot and derive the saturating count
  always_comb begin
    same_s     = (snapshot == prev_snap_r);
    cnt_next_s = {CNT_W{1'b0}};
    if (same_s) begin
      if (match_cnt_r == CNT_MAX) begin
        cnt_next_s = match_cnt_r;
      end else begin
        cnt_next_s = match_cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = {CNT_W{1'b0}};
    end
  end

  assign accept   = scan_done && same_s && (cnt_next_s == CNT_MAX);
  assign accepted = snapshot;

  // Track the last distinct snapshot and how many scans it has persisted
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_snap_r <= {SNAP_W{1'b0}};
      match_cnt_r <= {CNT_W{1'b0}};
    end else if (scan_done) begin
      if (!same_s) begin
        prev_snap_r <= snapshot;
      end
      match_cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: drives one-cold columns, synchronizes and
// samples the rows, debounces full-matrix snapshots and reports single
// key presses with a one-cycle strobe. Multi-key patterns are locked out.
module keypad_scan_decoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_ROWS-1:0] ROW_IN,
  output logic [NUM_COLS-1:0] COL_SEL,
  output logic [CODE_W-1:0]   KEY_CODE,
  output logic                KEY_VALID,
  output logic                KEY_HELD,
  output logic                MULTI_KEY
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_meta_r;
  logic [NUM_ROWS-1:0] row_sync_r;
  logic [DIV_W-1:0]    dwell_cnt_r;
  logic [1:0]          col_idx_r;
  logic [NUM_COLS-1:0] col_sel_r;
  logic [SNAP_W-1:0]   snapshot_r;
  logic [SNAP_W-1:0]   snapshot_next_s;
  logic                dwell_tc_s;
  logic                scan_done_s;
  logic [SNAP_W-1:0]   accepted_s;
  logic                accept_s;
  logic                one_hot_s;
  logic                all_zero_s;
  logic [CODE_W-1:0]   code_s;

  key_state_e          state_r;
  logic [CODE_W-1:0]   key_code_r;
  logic                key_valid_r;
  logic                key_held_r;
  logic                multi_key_r;

  // Snapshot bit b = col*4 + row becomes code {row, col}
  function automatic logic [CODE_W-1:0] encode_key(input logic [SNAP_W-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int b = 0; b < SNAP_W; b++) begin
      idx = v[b] ? 4'(b) : idx;
    end
    return {idx[1:0], idx[3:2]};
  endfunction

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= ROW_IN;
      row_sync_r <= row_meta_r;
    end
  end

  // Terminal count of the dwell, scan completion and the updated snapshot
  always_comb begin
    dwell_tc_s      = (dwell_cnt_r == DIV_MAX);
    scan_done_s     = dwell_tc_s && (col_idx_r == 2'd3);
    snapshot_next_s = snapshot_r;
    if (dwell_tc_s) begin
      snapshot_next_s[{col_idx_r, 2'b00} +: NUM_ROWS] = ~row_sync_r;
    end else begin
      snapshot_next_s = snapshot_r;
    end
  end

  // Dwell counter, column rotation and row sampling at end of dwell
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dwell_cnt_r <= {DIV_W{1'b0}};
      col_idx_r   <= 2'd0;
      col_sel_r   <= COL_SEL_0;
      snapshot_r  <= {SNAP_W{1'b0}};
    end else begin
      snapshot_r <= snapshot_next_s;
      if (dwell_tc_s) begin
        dwell_cnt_r <= {DIV_W{1'b0}};
        col_idx_r   <= col_idx_r + 2'd1;
        col_sel_r   <= col_sel_pattern(col_idx_r + 2'd1);
      end else begin
        dwell_cnt_r <= dwell_cnt_r + DIV_W'(1);
      end
    end
  end

  key_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .CLK       (CLK),
    .RESET     (RESET),
    .scan_done (scan_done_s),
    .snapshot  (snapshot_next_s),
    .accepted  (accepted_s),
    .accept    (accept_s)
  );

  // Classify the accepted pattern
  always_comb begin
    one_hot_s  = popcount_is_one(accepted_s);
    all_zero_s = (accepted_s == {SNAP_W{1'b0}});
    code_s     = encode_key(accepted_s);
  end

  // Key state machine: report single presses, lock out until full release
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
      multi_key_r <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          ST_IDLE: begin
            if (one_hot_s) begin
              state_r     <= ST_PRESSED;
              key_code_r  <= code_s;
              key_valid_r <= 1'b1;
              key_held_r  <= 1'b1;
            end else if (!all_zero_s) begin
              state_r     <= ST_MULTI;
              multi_key_r <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (all_zero_s) begin
              state_r    <= ST_IDLE;
              key_held_r <= 1'b0;
            end
          end
          ST_MULTI: begin
            if (all_zero_s) begin
              state_r     <= ST_IDLE;
              multi_key_r <= 1'b0;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            key_held_r  <= 1'b0;
            multi_key_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign COL_SEL   = col_sel_r;
  assign KEY_CODE  = key_code_r;
  assign KEY_VALID = key_valid_r;
  assign KEY_HELD  = key_held_r;
  assign MULTI_KEY = multi_key_r;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed testbench for keypad_scan_decoder (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A small keypad model pulls row lines low for pressed keys whose column is
// currently driven low.
module tb_keypad_scan_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_sel;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        multi_key;

  logic [15:0] keys;       // indexed by code {row, col}
  logic        bounce_hi;  // forces all contacts open while set

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int consec_cnt = 0;
  logic prev_valid = 1'b0;

  keypad_scan_decoder #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .CLK       (clk),
    .RESET     (reset),
    .ROW_IN    (row_in),
    .COL_SEL   (col_sel),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .KEY_HELD  (key_held),
    .MULTI_KEY (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !bounce_hi && (col_sel[c] == 1'b0)) row_in[r] = 1'b0;
      end
    end
  end

  // Count KEY_VALID pulses and back-to-back strobes
  always @(posedge clk) begin
    #1;
    if (key_valid) valid_cnt = valid_cnt + 1;
    if (key_valid && prev_valid) consec_cnt = consec_cnt + 1;
    prev_valid = key_valid;
  end

  task automatic wait_valid(input int base, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (valid_cnt != base) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // which: 0 = KEY_HELD, 1 = MULTI_KEY
  task automatic wait_level(input int which, input logic lvl, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (((which == 0) ? key_held : multi_key) == lvl) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] exp_pat [4];
    bit any_valid, any_held, any_multi;
    exp_pat[0] = 4'b1110; exp_pat[1] = 4'b1101;
    exp_pat[2] = 4'b1011; exp_pat[3] = 4'b0111;
    reset = 1'b1;
    idle(3);
    checks++;
    if ({col_sel, key_code, key_valid, key_held, multi_key} !== {4'b1110, 4'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got col=%b code=%h v=%b h=%b m=%b, want col=1110 code=0 v=0 h=0 m=0",
               col_sel, key_code, key_valid, key_held, multi_key);
    end
    reset = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if ((k % 4) == 2) begin
        checks++;
        if (col_sel !== exp_pat[(k / 4) % 4]) begin
          errors++;
          $display("FAIL col_rotation k=%0d: got %b want %b", k, col_sel, exp_pat[(k / 4) % 4]);
        end
      end
    end
    any_valid = 1'b0; any_held = 1'b0; any_multi = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      any_valid |= key_valid;
      any_held  |= key_held;
      any_multi |= multi_key;
    end
    checks++;
    if ({any_valid, any_held, any_multi} !== 3'b000) begin
      errors++;
      $display("FAIL idle_quiet: got valid=%b held=%b multi=%b want all 0", any_valid, any_held, any_multi);
    end
  endtask

  task automatic test_single_key;
    int base;
    bit got;
    idle(7);
    base = valid_cnt;
    keys[9] = 1'b1;
    wait_valid(base, 67, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_valid_timeout: got no KEY_VALID in 67 cycles, want one");
    end
    idle(40);
    checks++;
    if ({valid_cnt - base, key_code, key_held} !== {32'd1, 4'h9, 1'b1}) begin
      errors++;
      $display("FAIL single_result: got count=%0d code=%h held=%b want count=1 code=9 held=1",
               valid_cnt - base, key_code, key_held);
    end
    keys[9] = 1'b0;
    wait_level(0, 1'b0, 67, got);
    checks++;
    if (!got || (valid_cnt - base) != 1) begin
      errors++;
      $display("FAIL single_release: got held=%b count=%0d want held=0 count=1", key_held, valid_cnt - base);
    end
  endtask

  task automatic test_bounce;
    int base;
    bit got;
    idle(20);
    base = valid_cnt;
    keys[9] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bounce_hi = ((i / 5) % 2) == 1;
      @(negedge clk);
    end
    bounce_hi = 1'b0;
    idle(80);
    checks++;
    if ({valid_cnt - base, key_code, key_held} !== {32'd1, 4'h9, 1'b1}) begin
      errors++;
      $display("FAIL bounce_result: got count=%0d code=%h held=%b want count=1 code=9 held=1",
               valid_cnt - base, key_code, key_held);
    end
    keys[9] = 1'b0;
    wait_level(0, 1'b0, 80, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bounce_release: got held=%b want 0", key_held);
    end
  endtask

  task automatic test_multi;
    int base;
    bit got;
    idle(20);
    base = valid_cnt;
    keys[0] = 1'b1;
    keys[15] = 1'b1;
    wait_level(1, 1'b1, 80, got);
    idle(20);
    checks++;
    if (!got || {multi_key, key_held, valid_cnt - base} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL multi_lock: got multi=%b held=%b count=%0d want multi=1 held=0 count=0",
               multi_key, key_held, valid_cnt - base);
    end
    keys[0] = 1'b0;
    keys[15] = 1'b0;
    wait_level(1, 1'b0, 80, got);
    checks++;
    if (!got || (valid_cnt - base) != 0) begin
      errors++;
      $display("FAIL multi_release: got multi=%b count=%0d want multi=0 count=0", multi_key, valid_cnt - base);
    end
  endtask

  task automatic test_lockout;
    int base;
    bit got;
    idle(20);
    base = valid_cnt;
    keys[9] = 1'b1;
    wait_valid(base, 67, got);
    checks++;
    if (!got || key_code !== 4'h9) begin
      errors++;
      $display("FAIL lockout_first: got valid=%b code=%h want valid=1 code=9", got, key_code);
    end
    keys[3] = 1'b1;
    idle(80);
    checks++;
    if ({valid_cnt - base, key_code, key_held, multi_key} !== {32'd1, 4'h9, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lockout_add: got count=%0d code=%h held=%b multi=%b want count=1 code=9 held=1 multi=0",
               valid_cnt - base, key_code, key_held, multi_key);
    end
    keys[9] = 1'b0;
    keys[3] = 1'b0;
    wait_level(0, 1'b0, 80, got);
    checks++;
    if (!got || (valid_cnt - base) != 1) begin
      errors++;
      $display("FAIL lockout_release: got held=%b count=%0d want held=0 count=1", key_held, valid_cnt - base);
    end
    idle(10);
    keys[3] = 1'b1;
    wait_valid(base + 1, 67, got);
    checks++;
    if (!got || key_code !== 4'h3) begin
      errors++;
      $display("FAIL lockout_second: got valid=%b code=%h want valid=1 code=3", got, key_code);
    end
    keys[3] = 1'b0;
    wait_level(0, 1'b0, 80, got);
  endtask

  task automatic test_reset_mid_press;
    int base;
    bit got;
    idle(20);
    base = valid_cnt;
    keys[9] = 1'b1;
    wait_valid(base, 67, got);
    idle(10);
    reset = 1'b1;
    #1;
    checks++;
    if (!got || {col_sel, key_code, key_valid, key_held, multi_key} !== {4'b1110, 4'h0, 3'b000}) begin
      errors++;
      $display("FAIL midreset_values: got col=%b code=%h v=%b h=%b m=%b want col=1110 code=0 v=0 h=0 m=0",
               col_sel, key_code, key_valid, key_held, multi_key);
    end
    idle(3);
    reset = 1'b0;
    base = valid_cnt;
    wait_valid(base, 67, got);
    checks++;
    if (!got || {key_code, key_held} !== {4'h9, 1'b1}) begin
      errors++;
      $display("FAIL midreset_rereport: got valid=%b code=%h held=%b want valid=1 code=9 held=1",
               got, key_code, key_held);
    end
    keys[9] = 1'b0;
    wait_level(0, 1'b0, 80, got);
  endtask

  task automatic test_back_to_back;
    checks++;
    if (consec_cnt != 0) begin
      errors++;
      $display("FAIL valid_back_to_back: got %0d consecutive strobes want 0", consec_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    keys = 16'h0000;
    bounce_hi = 1'b0;
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_lockout();
    test_reset_mid_press();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
